// File: rtl/tnn_seq_pkg.sv
// Shared types, encodings and width helpers for the ternary popcount sequencer.
package tnn_seq_pkg;

    localparam int unsigned PC_IN_W  = 18;
    localparam int unsigned PC_OUT_W = 5;

    localparam logic [1:0] ACT_ZERO = 2'b00;
    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POS  = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Accumulator width: the approximate unit can report up to 2^PC_OUT_W-1 per chunk.
    function automatic int unsigned acc_w(input int unsigned chunks);
        return $clog2(chunks * ((1 << PC_OUT_W) - 1) + 1);
    endfunction

endpackage

// File: rtl/tnn_popcount_sequencer_act.sv
// Combinational ternary activation: +1 above thr, -1 below -thr, 0 inside the band.
module tnn_ternary_act
    import tnn_seq_pkg::*;
#(
    parameter int unsigned DIFF_W = 8,
    parameter int unsigned THR_W  = 8
) (
    input  logic [DIFF_W-1:0] diff_i,
    input  logic [THR_W-1:0]  thr_i,
    output logic [1:0]        act_c
);

    localparam int unsigned MAG_W = ((DIFF_W - 1) > THR_W) ? (DIFF_W - 1) : THR_W;
    localparam int unsigned CMP_W = MAG_W + 2;

    logic signed [CMP_W-1:0] diff_s;
    logic signed [CMP_W-1:0] thr_s;

    // Widen both operands so -thr and the signed diff compare without wrap.
    always_comb begin
        diff_s = CMP_W'($signed(diff_i));
        thr_s  = $signed(CMP_W'(thr_i));
        act_c  = ACT_ZERO;
        if (diff_s > thr_s) begin
            act_c = ACT_POS;
        end else if (diff_s < -thr_s) begin
            act_c = ACT_NEG;
        end
    end

endmodule

// File: rtl/tnn_popcount_sequencer.sv
// Time-multiplexes one external 18-input popcount unit over the pos/neg vectors of a neuron.
module tnn_popcount_sequencer
    import tnn_seq_pkg::*;
#(
    parameter int unsigned CHUNKS = 4,
    parameter int unsigned THR_W  = 8,
    localparam int unsigned ACC_W = acc_w(CHUNKS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CHUNKS*18-1:0]   pos_vec,
    input  logic [CHUNKS*18-1:0]   neg_vec,
    input  logic [THR_W-1:0]       thr,
    output logic [17:0]            pc_operand,
    input  logic [4:0]             pc_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W:0]         out_diff,
    output logic [1:0]             out_act
);

    localparam int unsigned VEC_W  = CHUNKS * PC_IN_W;
    localparam int unsigned DIFF_W = ACC_W + 1;
    localparam int unsigned IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHUNKS - 1);

    state_e              state_q, state_d;
    logic [VEC_W-1:0]    pos_q, pos_d;
    logic [VEC_W-1:0]    neg_q, neg_d;
    logic [THR_W-1:0]    thr_q, thr_d;
    logic [ACC_W-1:0]    acc_pos_q, acc_pos_d;
    logic [ACC_W-1:0]    acc_neg_q, acc_neg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIFF_W-1:0]   diff_q, diff_d;
    logic [1:0]          act_q, act_d;

    logic                last_chunk_c;
    logic [ACC_W-1:0]    pc_ext_c;
    logic [ACC_W-1:0]    acc_neg_sum_c;
    logic [DIFF_W-1:0]   diff_c;
    logic [1:0]          act_c;

    // Final result folds in the last neg chunk's count in the same cycle.
    assign last_chunk_c  = (idx_q == IDX_LAST);
    assign pc_ext_c      = ACC_W'(pc_count);
    assign acc_neg_sum_c = acc_neg_q + pc_ext_c;
    assign diff_c        = DIFF_W'(acc_pos_q) - DIFF_W'(acc_neg_sum_c);

    tnn_ternary_act #(
        .DIFF_W (DIFF_W),
        .THR_W  (THR_W)
    ) u_act (
        .diff_i (diff_c),
        .thr_i  (thr_q),
        .act_c  (act_c)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            neg_q     <= '0;
            thr_q     <= '0;
            acc_pos_q <= '0;
            acc_neg_q <= '0;
            idx_q     <= '0;
            diff_q    <= '0;
            act_q     <= ACT_ZERO;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            thr_q     <= thr_d;
            acc_pos_q <= acc_pos_d;
            acc_neg_q <= acc_neg_d;
            idx_q     <= idx_d;
            diff_q    <= diff_d;
            act_q     <= act_d;
        end
    end

    // Next-state: IDLE -> POS (CHUNKS cycles) -> NEG (CHUNKS cycles) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)     state_d = ST_POS;
            ST_POS:  if (last_chunk_c) state_d = ST_NEG;
            ST_NEG:  if (last_chunk_c) state_d = ST_DONE;
            ST_DONE: if (out_ready)    state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Datapath updates: capture on accept, accumulate per chunk, latch result on last neg chunk.
    always_comb begin
        pos_d     = pos_q;
        neg_d     = neg_q;
        thr_d     = thr_q;
        acc_pos_d = acc_pos_q;
        acc_neg_d = acc_neg_q;
        idx_d     = idx_q;
        diff_d    = diff_q;
        act_d     = act_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pos_d     = pos_vec;
                    neg_d     = neg_vec;
                    thr_d     = thr;
                    acc_pos_d = '0;
                    acc_neg_d = '0;
                    idx_d     = '0;
                end
            end
            ST_POS: begin
                acc_pos_d = acc_pos_q + pc_ext_c;
                idx_d     = last_chunk_c ? '0 : idx_q + IDX_W'(1);
            end
            ST_NEG: begin
                acc_neg_d = acc_neg_sum_c;
                idx_d     = last_chunk_c ? '0 : idx_q + IDX_W'(1);
                if (last_chunk_c) begin
                    diff_d = diff_c;
                    act_d  = act_c;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state only; pc_operand never depends on pc_count.
    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        out_valid  = (state_q == ST_DONE);
        pc_operand = '0;
        case (state_q)
            ST_POS:  pc_operand = pos_q[int'(idx_q) * PC_IN_W +: PC_IN_W];
            ST_NEG:  pc_operand = neg_q[int'(idx_q) * PC_IN_W +: PC_IN_W];
            default: pc_operand = '0;
        endcase
    end

    assign out_diff = diff_q;
    assign out_act  = act_q;

endmodule

// File: tb/tb_tnn_popcount_sequencer.sv
// Bench for tnn_popcount_sequencer: cycle-level reference model plus directed jobs.
`timescale 1ns/1ps
module tb_tnn_popcount_sequencer;

    localparam int unsigned CHUNKS = 4;
    localparam int unsigned THR_W  = 8;
    localparam int unsigned VW     = CHUNKS * 18;
    localparam int unsigned DW     = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic [VW-1:0]     pos_vec = '0;
    logic [VW-1:0]     neg_vec = '0;
    logic [THR_W-1:0]  thr = '0;
    logic              in_ready;
    logic              out_valid;
    logic [17:0]       pc_operand;
    logic [4:0]        pc_count;
    logic [DW-1:0]     out_diff;
    logic [1:0]        out_act;
    logic              force31 = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [17:0] last_ops [2*CHUNKS];

    always #5 clk = ~clk;

    // Popcount unit stand-in: exact, or an approximate unit stuck at its maximum.
    assign pc_count = force31 ? ((pc_operand != '0) ? 5'd31 : 5'd0)
                              : 5'($countones(pc_operand));

    tnn_popcount_sequencer #(
        .CHUNKS (CHUNKS),
        .THR_W  (THR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pos_vec    (pos_vec),
        .neg_vec    (neg_vec),
        .thr        (thr),
        .pc_operand (pc_operand),
        .pc_count   (pc_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_act    (out_act)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int unit_count(input logic [17:0] x);
        if (force31) return (x != '0) ? 31 : 0;
        return $countones(x);
    endfunction

    function automatic logic [17:0] chunk_of(input logic [VW-1:0] v, input int k);
        return v[k*18 +: 18];
    endfunction

    function automatic int vec_count(input logic [VW-1:0] v);
        int s;
        s = 0;
        for (int k = 0; k < CHUNKS; k++) s += unit_count(chunk_of(v, k));
        return s;
    endfunction

    function automatic logic [1:0] ternary(input int d, input int t);
        if (d > t)  return 2'b01;
        if (d < -t) return 2'b11;
        return 2'b00;
    endfunction

    // Reference model: a job takes 2*CHUNKS busy cycles, then waits for out_ready.
    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_DONE = 2;
    int            m_mode = M_IDLE;
    int            m_k = 0;
    logic [VW-1:0] m_pos = '0;
    logic [VW-1:0] m_neg = '0;
    int            m_diff = 0;
    logic [1:0]    m_act = 2'b00;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (in_valid) begin
                    m_pos  = pos_vec;
                    m_neg  = neg_vec;
                    m_diff = vec_count(pos_vec) - vec_count(neg_vec);
                    m_act  = ternary(m_diff, int'(thr));
                    m_k    = 0;
                    m_mode = M_BUSY;
                end
                M_BUSY: begin
                    m_k++;
                    if (m_k == 2*CHUNKS) m_mode = M_DONE;
                end
                default: if (out_ready) m_mode = M_IDLE;
            endcase
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [17:0] exp_op;
        exp_op = '0;
        if (m_mode == M_BUSY)
            exp_op = (m_k < CHUNKS) ? chunk_of(m_pos, m_k) : chunk_of(m_neg, m_k - CHUNKS);
        check("cyc_in_ready", in_ready, m_mode == M_IDLE);
        check("cyc_out_valid", out_valid, m_mode == M_DONE);
        check("cyc_pc_operand", pc_operand, exp_op);
        if (m_mode == M_DONE) begin
            check("cyc_out_diff", $signed(out_diff), m_diff);
            check("cyc_out_act", out_act, m_act);
        end
    end

    // One job with downstream ready; checks latency and hand-computed result.
    task automatic run_job(input string nm, input logic [VW-1:0] p, input logic [VW-1:0] n,
                           input logic [7:0] t, input int ediff, input logic [1:0] eact);
        int cyc;
        logic [17:0] ops [2*CHUNKS];
        for (int k = 0; k < 2*CHUNKS; k++) ops[k] = '0;
        @(negedge clk); #1;
        pos_vec = p; neg_vec = n; thr = t; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc <= 2*CHUNKS) ops[cyc-1] = pc_operand;
        end while (!out_valid && cyc < 40);
        check({nm, "_latency"}, cyc, 2*CHUNKS + 1);
        check({nm, "_model"}, m_diff, ediff);
        check({nm, "_diff"}, $signed(out_diff), ediff);
        check({nm, "_act"}, out_act, eact);
        last_ops = ops;
    endtask

    initial begin
        int cyc;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        // Reset with in_valid asserted: nothing may be accepted.
        rst_n = 1'b0; in_valid = 1'b1; pos_vec = '1; neg_vec = '0; thr = 8'd3;
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_pc_operand", pc_operand, 0);
            check("rst_out_diff", out_diff, 0);
            check("rst_out_act", out_act, 0);
        end
        #1 rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Positive saturation and operand sequence.
        run_job("sat", '1, '0, 8'd10, 72, 2'b01);
        for (int k = 0; k < 2*CHUNKS; k++)
            check("sat_operand_seq", last_ops[k], (k < CHUNKS) ? 18'h3FFFF : 18'h0);

        // Band and sign boundaries: pos 20, neg 30.
        run_job("band_thr10", {18'h0, 18'h0, 18'h3, 18'h3FFFF},
                {18'h0, 18'h0, 18'hFFF, 18'h3FFFF}, 8'd10, -10, 2'b00);
        run_job("band_thr9", {18'h0, 18'h0, 18'h3, 18'h3FFFF},
                {18'h0, 18'h0, 18'hFFF, 18'h3FFFF}, 8'd9, -10, 2'b11);
        run_job("zero_thr0", {18'h5, 18'h0, 18'h0, 18'h0},
                {18'h0, 18'h0, 18'h0, 18'h3}, 8'd0, 0, 2'b00);
        run_job("edge_eq_thr", {18'h0, 18'h0, 18'h0, 18'h3FF}, '0, 8'd10, 10, 2'b00);
        run_job("edge_above", {18'h0, 18'h0, 18'h0, 18'h3FF}, '0, 8'd9, 10, 2'b01);

        // Approximate unit returning 31 per pos chunk.
        force31 = 1'b1;
        run_job("ovf", {4{18'h00001}}, '0, 8'd0, 124, 2'b01);
        force31 = 1'b0;

        // Backpressure: result held while inputs churn.
        @(negedge clk); #1;
        pos_vec = {18'h0, 18'h0, 18'h0, 18'h3F}; neg_vec = {18'h0, 18'h0, 18'h0, 18'h1};
        thr = 8'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 40);
        check("bp_latency", cyc, 2*CHUNKS + 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            in_valid = 1'b1; pos_vec = '1; neg_vec = VW'(i); thr = 8'(i * 7);
            @(negedge clk);
            check("bp_diff", $signed(out_diff), 5);
            check("bp_act", out_act, 2'b01);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        #1;
        out_ready = 1'b1;
        pos_vec = {18'h0, 18'h0, 18'h0, 18'h7}; neg_vec = '0; thr = 8'd0; in_valid = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 40);
        check("bp_next_latency", cyc, 2*CHUNKS + 1);
        check("bp_next_diff", $signed(out_diff), 3);
        check("bp_next_act", out_act, 2'b01);

        // Reset during NEG chunk 2 discards the job.
        @(negedge clk); #1;
        pos_vec = '1; neg_vec = {18'h0, 18'h3FFFF, 18'h0, 18'h0}; thr = 8'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_operand", pc_operand, 18'h3FFFF);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        #1 rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("mid_no_stale", out_valid, 0);
        end
        run_job("post_mid_rst", '0, '0, 8'd0, 0, 2'b00);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
